fuzz_vec_driver: RTL and testbench
==================================

// Module: fuzz_vec_driver
// PURPOSE
//  Stimulus/checker end of the 96-bit in_data/out_data interface used by the fuzz DUT `top`.
//  - Generates pseudo-random in_data vectors from an LFSR and drives them to the DUT.
//  - Samples the DUT's out_data and compares it to an embedded golden model.
//  - Counts mismatches and records the first failure for the regression harness.
// PARAMETERS
//  DUT_LAT    2                Cycles from in_data change to sampling out_data (>=1).
//  CHK_MASK   96'h1<<32        out_data bits compared; all other bits ignored.
//  CNT_W      16               Width of vector and mismatch counters.
// PORTS
//  clk            in   1      Single clock; all logic on posedge.
//  rst            in   1      Synchronous, active-high reset.
//  start_i        in   1      Pulse: begin a run (ignored unless IDLE).
//  num_vec_i      in   CNT_W  Vectors per run; captured at start. 0 = finish immediately.
//  seed_i         in   32     LFSR seed, captured at start. 0 is replaced by 32'h1.
//  in_data        out  96     Stimulus to DUT.
//  out_data       in   96     DUT response.
//  busy_o         out  1      High from the accepted start until done.
//  done_o         out  1      One-cycle pulse when a run ends.
//  pass_o         out  1      Held: mismatch_cnt_o==0 for the last run. Valid at done.
//  mismatch_cnt_o out  CNT_W  Saturating mismatch count for the current run.
//  fail_idx_o     out  CNT_W  Index of the first failing vector; all-ones if none.
//  fail_vec_o     out  96     in_data of the first failing vector.
// BEHAVIOUR
//  Reset: FSM=IDLE; in_data=0; busy_o, done_o, mismatch_cnt_o=0; pass_o=1; fail_idx_o='1; fail_vec_o=0.
//  LFSR: Galois, 32-bit, taps 32'h80200003 (x^32+x^22+x^2+x+1); it advances once per cycle while stepping.
//  Vector = {s2,s1,s0}: three consecutive LFSR states, with s0 in bits [31:0].
//  FSM states:
//   IDLE: on start_i, capture num_vec_i and seed_i, clear the counters and fail regs, set busy_o.
//         Go to GEN, or to FIN if num_vec_i==0.
//   GEN: 3 cycles assembling the next vector. Go to DRIVE.
//   DRIVE: 1 cycle; in_data <= assembled vector, wait counter <= DUT_LAT. Go to WAIT.
//   WAIT: decrement the wait counter; in_data is held stable. At 0, go to CHECK.
//   CHECK: exp = golden(in_data). Mismatch if ((out_data ^ exp) & CHK_MASK) != 0.
//          On mismatch: increment mismatch_cnt_o (saturating at all-ones).
//          If this is the first failure, load fail_idx_o and fail_vec_o.
//          Increment vec_idx. If vec_idx == num-1, go to FIN; otherwise go to GEN.
//   FIN: done_o=1 for one cycle; pass_o = (mismatch_cnt_o==0); busy_o=0. Go to IDLE.
//  Golden model (bit 32 only; all other expected bits 0):
//   exp[32] = (in[21] | in[51]) & in[43] & in[42].
//   This is equivalent to the DUT's multiply/mux chain: {c,c}*{c,c} mod 4 = {0,c}.
//  Boundary conditions:
//   - start_i while busy: ignored. Captured num and seed are unaffected.
//   - rst mid-run: immediate return to reset values; no done_o pulse.
//   - num_vec_i = max: runs 2^CNT_W-1 vectors; vec_idx never wraps within a run.
//   - Counter saturation: mismatch_cnt_o stops at all-ones; pass_o stays 0.
//   - Outputs persist after done until the next accepted start.
//  Latency: a run takes num*(3+1+DUT_LAT+1)+2 cycles from start_i to done_o.
// STRUCTURE
//  Package fuzz_drv_pkg: typedef vec_t (logic[95:0]); enum state_t {IDLE,GEN,DRIVE,WAIT,CHECK,FIN};
//   LFSR_TAPS; function golden_top(vec_t) returning vec_t.
//  Sub-module lfsr32 (ports: clk, rst, load, seed, step, state). The golden model stays a package function.
// TESTING
//  1. Good DUT, seed=32'h1, num=16, DUT_LAT=2 -> done after 16*7+2 cycles; mismatch=0, pass=1, fail_idx='1.
//  2. out_data tied to 96'h1<<32 -> mismatch = count of vectors with exp[32]=0; fail_idx = first such index.
//     Cross-check fail_vec against the reference LFSR model.
//  3. seed=0 -> in_data sequence identical to seed=32'h1; num=0 -> done 2 cycles after start, pass=1.
//  4. Out-of-mask corruption: out_data[0] forced to 1 on a good DUT -> mismatch=0 (masked).
//  5. rst asserted during WAIT of vector 5 -> next cycle all outputs at reset values, no done.
//     A second start_i during busy has no effect on that run.
//  6. CNT_W=4, out_data stuck at 96'h1<<32, num=15 -> mismatch_cnt saturates at 4'hF, pass=0.

Source files
------------

// File: rtl/fuzz_drv_pkg.sv
// Shared types, constants and the golden response model for the fuzz vector driver.
package fuzz_drv_pkg;

  typedef logic [95:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    DRIVE,
    WAIT,
    CHECK,
    FIN
  } state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // A zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

  // Expected DUT response: only bit 32 is ever non-zero.
  function automatic vec_t golden_top(input vec_t vec);
    vec_t exp_v;
    exp_v     = '0;
    exp_v[32] = (vec[21] | vec[51]) & vec[43] & vec[42];
    return exp_v;
  endfunction

endpackage

// File: rtl/fuzz_vec_driver_if.sv
// Stimulus/response bus between the fuzz driver (master) and the DUT (slave).
interface fuzz_vec_driver_if;
  import fuzz_drv_pkg::*;

  vec_t in_data;
  vec_t out_data;

  modport master (output in_data, input out_data);
  modport slave (input in_data, output out_data);
endinterface

// File: rtl/fuzz_vec_driver_lfsr32.sv
// 32-bit Galois LFSR with seed load and step enable.
module lfsr32
  import fuzz_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_d;

  // Next state: load wins over step; a zero seed is substituted.
  always_comb begin
    state_d = state;
    if (load) begin
      state_d = (seed == 32'h0) ? LFSR_SEED_DEFAULT : seed;
    end else if (step) begin
      state_d = {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED_DEFAULT;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/fuzz_vec_driver.sv
// Fuzz stimulus/checker: drives LFSR vectors to the DUT, checks the response against
// the golden model and records the mismatch count and the first failing vector.
module fuzz_vec_driver
  import fuzz_drv_pkg::*;
#(
  parameter int unsigned DUT_LAT  = 2,
  parameter vec_t        CHK_MASK = 96'h1 << 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      num_vec_i,
  input  logic [31:0]           seed_i,
  fuzz_vec_driver_if.master     bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_W-1:0]      mismatch_cnt_o,
  output logic [CNT_W-1:0]      fail_idx_o,
  output vec_t                  fail_vec_o
);

  localparam int unsigned LAT_W = (DUT_LAT < 2) ? 1 : $clog2(DUT_LAT + 1);

  state_t           state_q, state_d;
  logic [1:0]       gen_cnt_q;
  logic [LAT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] vec_idx_q;
  vec_t             asm_q;

  logic        lfsr_load;
  logic        lfsr_step;
  logic [31:0] lfsr_state;
  logic        mismatch;
  logic        last_vec;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed_i),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign mismatch = |((bus.out_data ^ golden_top(bus.in_data)) & CHK_MASK);
  assign last_vec = (vec_idx_q == (num_q - CNT_W'(1)));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and LFSR control.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          lfsr_load = 1'b1;
          state_d   = (num_vec_i == '0) ? FIN : GEN;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        if (gen_cnt_q == 2'd2) begin
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        if (wait_cnt_q == LAT_W'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: state_d = last_vec ? FIN : GEN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: vector assembly, drive, response check and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      num_q          <= '0;
      vec_idx_q      <= '0;
      asm_q          <= '0;
      bus.in_data    <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      pass_o         <= 1'b1;
      mismatch_cnt_o <= '0;
      fail_idx_o     <= '1;
      fail_vec_o     <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            num_q          <= num_vec_i;
            vec_idx_q      <= '0;
            gen_cnt_q      <= '0;
            mismatch_cnt_o <= '0;
            fail_idx_o     <= '1;
            fail_vec_o     <= '0;
            busy_o         <= 1'b1;
          end
        end
        GEN: begin
          // Shift in from the top so the first state lands in bits [31:0].
          asm_q     <= {lfsr_state, asm_q[95:32]};
          gen_cnt_q <= gen_cnt_q + 2'd1;
        end
        DRIVE: begin
          bus.in_data <= asm_q;
          wait_cnt_q  <= LAT_W'(DUT_LAT);
          gen_cnt_q   <= '0;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - LAT_W'(1);
        end
        CHECK: begin
          if (mismatch) begin
            if (mismatch_cnt_o != '1) begin
              mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
            end
            if (mismatch_cnt_o == '0) begin
              fail_idx_o <= vec_idx_q;
              fail_vec_o <= bus.in_data;
            end
          end
          vec_idx_q <= vec_idx_q + CNT_W'(1);
        end
        FIN: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          pass_o <= (mismatch_cnt_o == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vec_driver.sv
// Directed self-checking bench for fuzz_vec_driver (CNT_W=16 and CNT_W=4 instances).
module tb_fuzz_vec_driver;
  import fuzz_drv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, start4;
  logic [15:0] num;
  logic [3:0]  num4;
  logic [31:0] seed, seed4;
  int          mode;  // 0 good, 1 stuck bit32, 2 good|bit0, 3 inverted bit32

  logic        busy, done, pass;
  logic [15:0] mcnt, fidx;
  vec_t        fvec;
  logic        busy4, done4, pass4;
  logic [3:0]  mcnt4, fidx4;
  vec_t        fvec4;

  int ncmp = 0;
  int nfail = 0;

  fuzz_vec_driver_if bus ();
  fuzz_vec_driver_if bus4 ();

  fuzz_vec_driver #(.DUT_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .num_vec_i(num), .seed_i(seed), .bus(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .mismatch_cnt_o(mcnt),
    .fail_idx_o(fidx), .fail_vec_o(fvec)
  );

  fuzz_vec_driver #(.DUT_LAT(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .num_vec_i(num4), .seed_i(seed4), .bus(bus4),
    .busy_o(busy4), .done_o(done4), .pass_o(pass4), .mismatch_cnt_o(mcnt4),
    .fail_idx_o(fidx4), .fail_vec_o(fvec4)
  );

  // Reference response bit via the DUT's {c,c}*{c,c} mod 4 formulation.
  function automatic logic ref_exp32(input vec_t v);
    logic       c;
    logic [1:0] p;
    c = (v[21] | v[51]) & v[43] & v[42];
    p = {c, c} * {c, c};
    return p[0];
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic vec_t resp(input vec_t v, input int m);
    vec_t r;
    r = '0;
    case (m)
      0: r[32] = ref_exp32(v);
      1: r[32] = 1'b1;
      2: begin r[32] = ref_exp32(v); r[0] = 1'b1; end
      default: r[32] = ~ref_exp32(v);
    endcase
    return r;
  endfunction

  always_comb bus.out_data = resp(bus.in_data, mode);
  always_comb bus4.out_data = resp(bus4.in_data, mode);

  task automatic model_run(input logic [31:0] sd, input int n, input int m, input int maxc,
                           output int mism, output logic [15:0] fi, output vec_t fv,
                           output vec_t v0);
    logic [31:0] s;
    vec_t        v, r;
    s    = (sd == 32'h0) ? 32'h1 : sd;
    mism = 0;
    fi   = 16'hFFFF;
    fv   = '0;
    v0   = '0;
    for (int k = 0; k < n; k++) begin
      v[31:0]  = s; s = ref_next(s);
      v[63:32] = s; s = ref_next(s);
      v[95:64] = s; s = ref_next(s);
      if (k == 0) v0 = v;
      r = resp(v, m);
      if (r[32] != ref_exp32(v)) begin
        if (mism == 0) begin fi = 16'(k); fv = v; end
        if (mism < maxc) mism++;
      end
    end
  endtask

  task automatic check(input string tag, input vec_t obs, input vec_t exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_run(input int which, input logic [15:0] n, input logic [31:0] s);
    @(negedge clk);
    if (which == 4) begin start4 = 1'b1; num4 = n[3:0]; seed4 = s; end
    else begin start = 1'b1; num = n; seed = s; end
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // lat counts cycles from the start cycle (1) to the cycle where done is seen.
  task automatic wait_done(input int which, input int bound, input int glitch_at,
                           output int lat, output vec_t vec5);
    lat  = 1;
    vec5 = '0;
    while (!((which == 4) ? done4 : done) && lat < bound) begin
      @(negedge clk);
      lat++;
      if (lat == 5) vec5 = (which == 4) ? bus4.in_data : bus.in_data;
      start = (lat == glitch_at);
      if (lat == glitch_at) begin num = 16'd10; seed = 32'h0000_ABCD; end
    end
    start = 1'b0;
  endtask

  int          lat, mexp, dcount;
  logic [15:0] fiexp;
  vec_t        fvexp, v0exp, v5, fv_s1;
  int          m_s1;
  logic [15:0] fi_s1;

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; num = '0; num4 = '0; seed = '0; seed4 = '0;
    mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_pass", 96'(pass), 96'(1));
    check("rst_mcnt", 96'(mcnt), 96'(0));
    check("rst_fidx", 96'(fidx), 96'(16'hFFFF));
    check("rst_fvec", fvec, '0);
    check("rst_in_data", bus.in_data, '0);

    // 1: good DUT, seed 1, 16 vectors
    mode = 0;
    model_run(32'h1, 16, 0, 65535, mexp, fiexp, fvexp, v0exp);
    start_run(0, 16'd16, 32'h1);
    check("t1_busy_after_start", 96'(busy), 96'(1));
    wait_done(0, 200, -1, lat, v5);
    check("t1_latency", 96'(lat), 96'(16 * 7 + 2));
    check("t1_vec0", v5, v0exp);
    check("t1_mcnt", 96'(mcnt), 96'(0));
    check("t1_pass", 96'(pass), 96'(1));
    check("t1_fidx", 96'(fidx), 96'(16'hFFFF));
    check("t1_busy_at_done", 96'(busy), 96'(0));
    repeat (4) @(negedge clk);
    check("t1_done_pulse", 96'(done), 96'(0));
    check("t1_pass_persist", 96'(pass), 96'(1));

    // 2: out_data stuck at bit 32
    mode = 1;
    model_run(32'h1, 16, 1, 65535, m_s1, fi_s1, fv_s1, v0exp);
    start_run(0, 16'd16, 32'h1);
    wait_done(0, 200, -1, lat, v5);
    check("t2_mcnt", 96'(mcnt), 96'(m_s1));
    check("t2_fidx", 96'(fidx), 96'(fi_s1));
    check("t2_fvec", fvec, fv_s1);
    check("t2_pass", 96'(pass), 96'(m_s1 == 0));

    model_run(32'hDEAD_BEEF, 20, 1, 65535, mexp, fiexp, fvexp, v0exp);
    start_run(0, 16'd20, 32'hDEAD_BEEF);
    wait_done(0, 250, -1, lat, v5);
    check("t2b_latency", 96'(lat), 96'(20 * 7 + 2));
    check("t2b_vec0", v5, v0exp);
    check("t2b_mcnt", 96'(mcnt), 96'(mexp));
    check("t2b_fidx", 96'(fidx), 96'(fiexp));
    check("t2b_fvec", fvec, fvexp);

    // 3: seed 0 behaves as seed 1; num 0 finishes immediately
    start_run(0, 16'd16, 32'h0);
    wait_done(0, 200, -1, lat, v5);
    model_run(32'h1, 16, 1, 65535, mexp, fiexp, fvexp, v0exp);
    check("t3_seed0_vec0", v5, v0exp);
    check("t3_seed0_mcnt", 96'(mcnt), 96'(m_s1));
    check("t3_seed0_fidx", 96'(fidx), 96'(fi_s1));
    check("t3_seed0_fvec", fvec, fv_s1);
    start_run(0, 16'd0, 32'h1234);
    wait_done(0, 20, -1, lat, v5);
    check("t3_num0_latency", 96'(lat), 96'(2));
    check("t3_num0_mcnt", 96'(mcnt), 96'(0));
    check("t3_num0_pass", 96'(pass), 96'(1));
    check("t3_num0_fidx", 96'(fidx), 96'(16'hFFFF));

    // 4: corruption outside the compare mask
    mode = 2;
    start_run(0, 16'd10, 32'h5);
    wait_done(0, 200, -1, lat, v5);
    check("t4_masked_mcnt", 96'(mcnt), 96'(0));
    check("t4_masked_pass", 96'(pass), 96'(1));

    // 5a: second start during busy is ignored
    mode = 1;
    model_run(32'h7, 4, 1, 65535, mexp, fiexp, fvexp, v0exp);
    start_run(0, 16'd4, 32'h7);
    wait_done(0, 100, 10, lat, v5);
    check("t5_ignore_latency", 96'(lat), 96'(4 * 7 + 2));
    check("t5_ignore_mcnt", 96'(mcnt), 96'(mexp));
    check("t5_ignore_fidx", 96'(fidx), 96'(fiexp));
    check("t5_ignore_fvec", fvec, fvexp);
    repeat (3) @(negedge clk);
    check("t5_ignore_idle", 96'(busy), 96'(0));

    // 5b: reset during WAIT of vector 5
    mode = 3;
    start_run(0, 16'd10, 32'h9);
    dcount = 0;
    repeat (39) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t5_busy_before_rst", 96'(busy), 96'(1));
    check("t5_mcnt_before_rst", 96'(mcnt), 96'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", 96'(busy), 96'(0));
    check("t5_rst_done", 96'(done), 96'(0));
    check("t5_rst_pass", 96'(pass), 96'(1));
    check("t5_rst_mcnt", 96'(mcnt), 96'(0));
    check("t5_rst_fidx", 96'(fidx), 96'(16'hFFFF));
    check("t5_rst_fvec", fvec, '0);
    check("t5_rst_in_data", bus.in_data, '0);
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t5_no_done", 96'(dcount), 96'(0));

    // 6: CNT_W=4, maximum run length, all vectors mismatching
    mode = 3;
    start_run(4, 16'd15, 32'h3);
    wait_done(4, 200, -1, lat, v5);
    check("t6_latency", 96'(lat), 96'(15 * 7 + 2));
    check("t6_mcnt_sat", 96'(mcnt4), 96'(4'hF));
    check("t6_pass", 96'(pass4), 96'(0));
    check("t6_fidx", 96'(fidx4), 96'(0));
    mode = 1;
    model_run(32'h1, 15, 1, 15, mexp, fiexp, fvexp, v0exp);
    start_run(4, 16'd15, 32'h1);
    wait_done(4, 200, -1, lat, v5);
    check("t6_stuck_mcnt", 96'(mcnt4), 96'(mexp));
    check("t6_stuck_fidx", 96'(fidx4), 96'(fiexp[3:0]));
    check("t6_stuck_fvec", fvec4, fvexp);
    check("t6_stuck_pass", 96'(pass4), 96'(mexp == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
